riscv_alu_issue: RTL and testbench

Decode/issue stage that drives the RV32I ALU, acting as its initiator. It accepts one instruction per cycle, together with the PC and the register-file read data, over a valid/ready handshake. It decodes the ALU-class opcodes (OP, OP-IMM, LUI, AUIPC) into operand_a, operand_b and a 4-bit ALU op, and presents them registered to the ALU/execute stage through a 2-entry skid buffer, so full throughput is sustained under backpressure.

---
 rtl/riscv_alu_issue.sv | 223 ++++++++++++++++++++++
 tb/tb_riscv_alu_issue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_issue.sv
// RV32I ALU-class decode/issue stage with a 2-entry skid buffer towards the ALU.
// Optional statistics counters are enabled by defining RISCV_ALU_ISSUE_STATS_EN.
module riscv_alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            alu_valid_o,
  input  logic            alu_ready_i,
  output logic [XLEN-1:0] operand_a_o,
  output logic [XLEN-1:0] operand_b_o,
  output logic [3:0]      alu_op_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic            illegal_o
`ifdef RISCV_ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]     issued_cnt_o,
  output logic [31:0]     stall_cnt_o
`endif
);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLL    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_SLT    = 4'b1000,
    ALU_SLTU   = 4'b1001,
    ALU_PASS_A = 4'b1010,
    ALU_PASS_B = 4'b1011
  } alu_op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_e         op;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
  } bundle_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, instr_i[24:20]};

  bundle_t dec;
  logic    legal;

  // Shift encodings fold into the shared funct3 map; only funct7 legality differs.
  always_comb begin
    dec   = '0;
    dec.op = ALU_ADD;
    legal = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        dec.a = rs1_data_i;
        dec.b = imm_i;
        legal = 1'b1;
        case (funct3)
          3'b000: dec.op = ALU_ADD;
          3'b010: dec.op = ALU_SLT;
          3'b011: dec.op = ALU_SLTU;
          3'b100: dec.op = ALU_XOR;
          3'b110: dec.op = ALU_OR;
          3'b111: dec.op = ALU_AND;
          3'b001: begin
            dec.op = ALU_SLL;
            dec.b  = shamt;
            legal  = (funct7 == F7_BASE);
          end
          default: begin
            dec.b = shamt;
            if (funct7 == F7_BASE)     dec.op = ALU_SRL;
            else if (funct7 == F7_ALT) dec.op = ALU_SRA;
            else                       legal  = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        dec.a = rs1_data_i;
        dec.b = rs2_data_i;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  dec.op = ALU_ADD;
            3'b001:  dec.op = ALU_SLL;
            3'b010:  dec.op = ALU_SLT;
            3'b011:  dec.op = ALU_SLTU;
            3'b100:  dec.op = ALU_XOR;
            3'b101:  dec.op = ALU_SRL;
            3'b110:  dec.op = ALU_OR;
            default: dec.op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            legal  = 1'b1;
            dec.op = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            legal  = 1'b1;
            dec.op = ALU_SRA;
          end
        end
      end
      OPC_LUI: begin
        legal  = 1'b1;
        dec.op = ALU_PASS_B;
        dec.a  = '0;
        dec.b  = imm_u;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        dec.op = ALU_ADD;
        dec.a  = pc_i;
        dec.b  = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.a  = '0;
      dec.b  = '0;
      dec.op = ALU_ADD;
    end
    dec.rd      = rd;
    dec.we      = legal && (rd != 5'd0);
    dec.illegal = !legal;
  end

  bundle_t or_q;
  bundle_t sr_q;
  logic    or_valid;
  logic    sr_valid;
  logic    accept;
  logic    or_free;

  assign in_ready_o = !sr_valid && !rst_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign or_free    = !or_valid || alu_ready_i;

  // The skid entry always drains into the output register first to keep FIFO order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      or_valid <= 1'b0;
      sr_valid <= 1'b0;
      or_q     <= '0;
      sr_q     <= '0;
    end else if (flush_i) begin
      or_valid <= 1'b0;
      sr_valid <= 1'b0;
    end else if (or_free) begin
      if (sr_valid) begin
        or_q     <= sr_q;
        or_valid <= 1'b1;
        sr_valid <= accept;
        if (accept) sr_q <= dec;
      end else begin
        or_valid <= accept;
        if (accept) or_q <= dec;
      end
    end else if (accept) begin
      sr_q     <= dec;
      sr_valid <= 1'b1;
    end
  end

  assign alu_valid_o = or_valid;
  assign operand_a_o = or_q.a;
  assign operand_b_o = or_q.b;
  assign alu_op_o    = or_q.op;
  assign rd_addr_o   = or_q.rd;
  assign rd_we_o     = or_q.we;
  assign illegal_o   = or_q.illegal;

`ifdef RISCV_ALU_ISSUE_STATS_EN
  logic [31:0] issued_cnt;
  logic [31:0] stall_cnt;

  // Counters survive flushes; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (or_valid && alu_ready_i)  issued_cnt <= issued_cnt + 32'd1;
      if (or_valid && !alu_ready_i) stall_cnt  <= stall_cnt + 32'd1;
    end
  end

  assign issued_cnt_o = issued_cnt;
  assign stall_cnt_o  = stall_cnt;
`endif

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Directed bench for riscv_alu_issue: decode vectors, backpressure, flush and reset.
module tb_riscv_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;

  int passed = 0;
  int total  = 0;

  riscv_alu_issue dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .instr_i     (instr),
    .pc_i        (pc),
    .rs1_data_i  (rs1_data),
    .rs2_data_i  (rs2_data),
    .alu_valid_o (alu_valid),
    .alu_ready_i (alu_ready),
    .operand_a_o (operand_a),
    .operand_b_o (operand_b),
    .alu_op_o    (alu_op),
    .rd_addr_o   (rd_addr),
    .rd_we_o     (rd_we),
    .illegal_o   (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                               input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v;
    instr    = ins;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBundle(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic we,
                             input logic ill);
    checkOutput({tag, ".valid"},   32'(alu_valid), 32'd1);
    checkOutput({tag, ".op"},      32'(alu_op),    32'(op));
    checkOutput({tag, ".a"},       operand_a,      a);
    checkOutput({tag, ".b"},       operand_b,      b);
    checkOutput({tag, ".rd"},      32'(rd_addr),   32'(rd));
    checkOutput({tag, ".we"},      32'(rd_we),     32'(we));
    checkOutput({tag, ".illegal"}, 32'(illegal),   32'(ill));
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, ".valid"},   32'(alu_valid), 32'd0);
    checkOutput({tag, ".op"},      32'(alu_op),    32'd0);
    checkOutput({tag, ".a"},       operand_a,      32'd0);
    checkOutput({tag, ".b"},       operand_b,      32'd0);
    checkOutput({tag, ".rd"},      32'(rd_addr),   32'd0);
    checkOutput({tag, ".we"},      32'(rd_we),     32'd0);
    checkOutput({tag, ".illegal"}, 32'(illegal),   32'd0);
  endtask

  // ADDI x1, x0, 1: operand A carries the rs1 tag so issue order is visible.
  localparam logic [31:0] ADDI_X1 = 32'h00100093;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    alu_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("rst.in_ready", 32'(in_ready), 32'd0);
    checkZeroOutputs("rst");
    rst = 1'b0;
    #1;
    checkOutput("post_rst.in_ready", 32'(in_ready), 32'd1);

    applyStimulus(1'b1, 32'hFFF08293, 32'h0, 32'd10, 32'h0);
    tick();
    checkBundle("addi", 4'b0000, 32'd10, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h40415193, 32'h0, 32'h80, 32'h0);
    tick();
    checkBundle("srai", 4'b0111, 32'h80, 32'd4, 5'd3, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h20415193, 32'h0, 32'h80, 32'h0);
    tick();
    checkBundle("srai_bad_f7", 4'b0000, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h123453B7, 32'h0, 32'h55, 32'h0);
    tick();
    checkBundle("lui", 4'b1011, 32'd0, 32'h12345000, 5'd7, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h00001097, 32'h100, 32'h55, 32'h0);
    tick();
    checkBundle("auipc", 4'b0000, 32'h100, 32'h1000, 5'd1, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h40310233, 32'h0, 32'd20, 32'd7);
    tick();
    checkBundle("sub", 4'b0001, 32'd20, 32'd7, 5'd4, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h4020D033, 32'h0, 32'hF0, 32'd3);
    tick();
    checkBundle("sra", 4'b0111, 32'hF0, 32'd3, 5'd0, 1'b0, 1'b0);

    applyStimulus(1'b1, 32'h0020B033, 32'h0, 32'd1, 32'd2);
    tick();
    checkBundle("sltu_x0", 4'b1001, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0);

    applyStimulus(1'b1, 32'h40209033, 32'h0, 32'd1, 32'd2);
    tick();
    checkBundle("sll_bad_f7", 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h0000056F, 32'h0, 32'd9, 32'd9);
    tick();
    checkBundle("jal_illegal", 4'b0000, 32'd0, 32'd0, 5'd10, 1'b0, 1'b1);

    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("drain.valid", 32'(alu_valid), 32'd0);

    // Backpressure: A and B buffered, C refused until the stage frees up.
    alu_ready = 1'b0;
    applyStimulus(1'b1, ADDI_X1, 32'h0, 32'hA, 32'h0);
    tick();
    checkOutput("bp.A.a", operand_a, 32'hA);
    checkOutput("bp.A.in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, ADDI_X1, 32'h0, 32'hB, 32'h0);
    tick();
    checkOutput("bp.full.in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp.full.a", operand_a, 32'hA);
    applyStimulus(1'b1, ADDI_X1, 32'h0, 32'hC, 32'h0);
    tick();
    checkOutput("bp.hold1.valid", 32'(alu_valid), 32'd1);
    checkOutput("bp.hold1.a", operand_a, 32'hA);
    checkOutput("bp.hold1.b", operand_b, 32'd1);
    checkOutput("bp.hold1.in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("bp.hold2.a", operand_a, 32'hA);
    alu_ready = 1'b1;
    tick();
    checkOutput("bp.B.valid", 32'(alu_valid), 32'd1);
    checkOutput("bp.B.a", operand_a, 32'hB);
    checkOutput("bp.B.in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("bp.C.valid", 32'(alu_valid), 32'd1);
    checkOutput("bp.C.a", operand_a, 32'hC);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("bp.empty.valid", 32'(alu_valid), 32'd0);

    // Flush with both entries full and a bundle presented.
    alu_ready = 1'b0;
    applyStimulus(1'b1, ADDI_X1, 32'h0, 32'hA, 32'h0);
    tick();
    applyStimulus(1'b1, ADDI_X1, 32'h0, 32'hB, 32'h0);
    tick();
    checkOutput("fl.full.in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    applyStimulus(1'b1, ADDI_X1, 32'h0, 32'hD, 32'h0);
    tick();
    checkOutput("fl.valid", 32'(alu_valid), 32'd0);
    checkOutput("fl.in_ready", 32'(in_ready), 32'd1);
    flush     = 1'b0;
    alu_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("fl.after.valid", 32'(alu_valid), 32'd0);

    // Flush while ready is high: the presented bundle must still be dropped.
    alu_ready = 1'b0;
    applyStimulus(1'b1, ADDI_X1, 32'h0, 32'hA, 32'h0);
    tick();
    flush = 1'b1;
    applyStimulus(1'b1, ADDI_X1, 32'h0, 32'hD, 32'h0);
    tick();
    checkOutput("fl2.valid", 32'(alu_valid), 32'd0);
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("fl2.after.valid", 32'(alu_valid), 32'd0);

    // Reset in the middle of a stall with both entries occupied.
    applyStimulus(1'b1, ADDI_X1, 32'h0, 32'hA, 32'h0);
    tick();
    applyStimulus(1'b1, ADDI_X1, 32'h0, 32'hB, 32'h0);
    tick();
    checkOutput("mrst.full.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("mrst.in_ready", 32'(in_ready), 32'd0);
    checkZeroOutputs("mrst");
    rst = 1'b0;
    #1;
    checkOutput("mrst.after.in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    alu_ready = 1'b1;
    tick();
    checkOutput("mrst.after.valid", 32'(alu_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
